// File: rtl/pic_priority_inta_sequencer.sv
// 8259 PIC core: IRR/ISR, rotating priority, INT generation and 8086-mode two-pulse INTA vector sequence.
// Build macro AEOI_ROTATE_EN: when defined, auto-EOI with the rotate flag set rotates priority at the end of ACK2.
module pic_priority_inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_IR      = 8
) (
  input  logic              clk,
  input  logic              rst_neg,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_neg,
  input  logic [NUM_IR-1:0] imr,
  input  logic              level_trigger_flag_and_edge_level_neg,
  input  logic              aeoi_and_eoi_neg_flag,
  input  logic              automatic_rotation_mode_flag,
  input  logic [4:0]        last_five_bits_of_vector_address,
  input  logic              ocw2_output_flag,
  input  logic [2:0]        control_bits,
  input  logic [2:0]        ir_level,
  input  logic              ready_to_accept_interrupts_flag,
  output logic              int_out,
  output logic [7:0]        vector_out,
  output logic              vector_oe,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK1  = 2'd1;
  localparam logic [1:0] ST_WAIT2 = 2'd2;
  localparam logic [1:0] ST_ACK2  = 2'd3;

  // Returns {found, index} of the highest-ranked set bit; rank 0 sits just above lowest_prio.
  function automatic logic [3:0] f_top(input logic [NUM_IR-1:0] vec, input logic [2:0] lp);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      idx = lp + 3'd1 + k[2:0];
      res = vec[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  function automatic logic [2:0] f_rank(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

  function automatic logic [NUM_IR-1:0] f_onehot(input logic [2:0] idx);
    return {{(NUM_IR-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [SYNC_STAGES-1:0][NUM_IR-1:0] r_ir_sync;
  logic [SYNC_STAGES-1:0]             r_inta_sync;
  logic [SYNC_STAGES-1:0]             r_ocw2_sync;
  logic [NUM_IR-1:0] r_ir_d;
  logic              r_inta_d, r_ocw2_d, r_ocw2_pend;
  logic [1:0]        r_state;
  logic [2:0]        r_idx, r_lowest_prio;
  logic              r_spur, r_int, r_oe;
  logic [7:0]        r_vec;
  logic [NUM_IR-1:0] r_irr, r_isr;

  logic [NUM_IR-1:0] w_ir_s, w_ir_rise, w_irr_nxt, w_isr_nxt, w_set_mask, w_clr_mask, w_ack_clr, w_top_mask;
  logic              w_inta_fall, w_inta_rise, w_ocw2_edge, w_pending, w_int_nxt;
  logic [3:0]        w_cand, w_isr_top;
  logic [1:0]        w_state_nxt;
  logic [2:0]        w_idx_nxt, w_lp_nxt;
  logic              w_spur_nxt, w_oe_nxt;
  logic [7:0]        w_vec_nxt;

`ifndef AEOI_ROTATE_EN
  logic w_unused_rot;
  assign w_unused_rot = automatic_rotation_mode_flag;
`endif

  assign w_ir_s      = r_ir_sync[SYNC_STAGES-1];
  assign w_ir_rise   = w_ir_s & ~r_ir_d;
  assign w_inta_fall = r_inta_d & ~r_inta_sync[SYNC_STAGES-1];
  assign w_inta_rise = ~r_inta_d & r_inta_sync[SYNC_STAGES-1];
  assign w_ocw2_edge = r_ocw2_sync[SYNC_STAGES-1] ^ r_ocw2_d;

  assign w_cand     = f_top(r_irr & ~imr, r_lowest_prio);
  assign w_isr_top  = f_top(r_isr, r_lowest_prio);
  assign w_top_mask = w_isr_top[3] ? f_onehot(w_isr_top[2:0]) : {NUM_IR{1'b0}};
  // Fully nested: a request only interrupts when it outranks everything in service.
  assign w_pending  = w_cand[3] && (!w_isr_top[3] ||
                      (f_rank(w_cand[2:0], r_lowest_prio) < f_rank(w_isr_top[2:0], r_lowest_prio)));

  // Synchronizers, delayed copies for edge detection and the OCW2 execute strobe
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      r_ir_sync   <= {(SYNC_STAGES*NUM_IR){1'b0}};
      r_inta_sync <= {SYNC_STAGES{1'b1}};
      r_ocw2_sync <= {SYNC_STAGES{1'b0}};
      r_ir_d      <= {NUM_IR{1'b0}};
      r_inta_d    <= 1'b1;
      r_ocw2_d    <= 1'b0;
      r_ocw2_pend <= 1'b0;
    end else begin
      r_ir_sync   <= {r_ir_sync[SYNC_STAGES-2:0], ir};
      r_inta_sync <= {r_inta_sync[SYNC_STAGES-2:0], inta_neg};
      r_ocw2_sync <= {r_ocw2_sync[SYNC_STAGES-2:0], ocw2_output_flag};
      r_ir_d      <= w_ir_s;
      r_inta_d    <= r_inta_sync[SYNC_STAGES-1];
      r_ocw2_d    <= r_ocw2_sync[SYNC_STAGES-1];
      r_ocw2_pend <= w_ocw2_edge;
    end
  end

  // INTA sequencer, OCW2 command execution and next IRR/ISR/INT values
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_spur_nxt  = r_spur;
    w_vec_nxt   = r_vec;
    w_oe_nxt    = r_oe;
    w_lp_nxt    = r_lowest_prio;
    w_set_mask  = {NUM_IR{1'b0}};
    w_clr_mask  = {NUM_IR{1'b0}};
    w_ack_clr   = {NUM_IR{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_inta_fall) begin
          w_state_nxt = ST_ACK1;
          if (w_cand[3]) begin
            w_idx_nxt  = w_cand[2:0];
            w_spur_nxt = 1'b0;
            w_set_mask = f_onehot(w_cand[2:0]);
            w_ack_clr  = f_onehot(w_cand[2:0]);
          end else begin
            w_idx_nxt  = 3'd7;
            w_spur_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (w_inta_rise) w_state_nxt = ST_WAIT2;
        else             w_state_nxt = ST_ACK1;
      end
      ST_WAIT2: begin
        if (w_inta_fall) begin
          w_state_nxt = ST_ACK2;
          w_vec_nxt   = {last_five_bits_of_vector_address, r_idx};
          w_oe_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT2;
        end
      end
      ST_ACK2: begin
        if (w_inta_rise) begin
          w_state_nxt = ST_IDLE;
          w_oe_nxt    = 1'b0;
          // A spurious acknowledge never set an ISR bit, so auto-EOI must not clear one.
          if (aeoi_and_eoi_neg_flag && !r_spur) w_clr_mask = f_onehot(r_idx);
          else                                  w_clr_mask = {NUM_IR{1'b0}};
`ifdef AEOI_ROTATE_EN
          if (aeoi_and_eoi_neg_flag && !r_spur && automatic_rotation_mode_flag) w_lp_nxt = r_idx;
          else                                                                  w_lp_nxt = r_lowest_prio;
`endif
        end else begin
          w_state_nxt = ST_ACK2;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (r_ocw2_pend) begin
      case (control_bits)
        3'b001: w_clr_mask = w_clr_mask | w_top_mask;
        3'b011: w_clr_mask = w_clr_mask | f_onehot(ir_level);
        3'b101: begin
          w_clr_mask = w_clr_mask | w_top_mask;
          if (w_isr_top[3]) w_lp_nxt = w_isr_top[2:0];
          else              w_lp_nxt = w_lp_nxt;
        end
        3'b111: begin
          w_clr_mask = w_clr_mask | f_onehot(ir_level);
          w_lp_nxt   = ir_level;
        end
        3'b110:  w_lp_nxt = ir_level;
        default: w_clr_mask = w_clr_mask;
      endcase
    end else begin
      w_clr_mask = w_clr_mask;
    end

    // The acknowledge set is applied after the clear so it wins on a shared bit.
    w_isr_nxt = (r_isr & ~w_clr_mask) | w_set_mask;
    if (level_trigger_flag_and_edge_level_neg) w_irr_nxt = w_ir_s;
    else                                       w_irr_nxt = (r_irr | w_ir_rise) & w_ir_s & ~w_ack_clr;
    w_int_nxt = (r_state == ST_IDLE) && !w_inta_fall && w_pending;
  end

  // Architectural state; not-ready holds the core in its quiescent state
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      r_state       <= ST_IDLE;
      r_idx         <= 3'd7;
      r_spur        <= 1'b0;
      r_lowest_prio <= 3'd7;
      r_irr         <= {NUM_IR{1'b0}};
      r_isr         <= {NUM_IR{1'b0}};
      r_int         <= 1'b0;
      r_vec         <= 8'h00;
      r_oe          <= 1'b0;
    end else if (!ready_to_accept_interrupts_flag) begin
      r_state       <= ST_IDLE;
      r_lowest_prio <= 3'd7;
      r_irr         <= {NUM_IR{1'b0}};
      r_isr         <= {NUM_IR{1'b0}};
      r_int         <= 1'b0;
      r_oe          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_spur        <= w_spur_nxt;
      r_lowest_prio <= w_lp_nxt;
      r_irr         <= w_irr_nxt;
      r_isr         <= w_isr_nxt;
      r_int         <= w_int_nxt;
      r_vec         <= w_vec_nxt;
      r_oe          <= w_oe_nxt;
    end
  end

  assign int_out    = r_int;
  assign vector_out = r_vec;
  assign vector_oe  = r_oe;
  assign irr        = r_irr;
  assign isr        = r_isr;

endmodule

// File: tb/tb_pic_priority_inta_sequencer.sv
// Scoreboard bench for pic_priority_inta_sequencer: expected vectors queued per INTA sequence, other state checked directly.
module tb_pic_priority_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_neg;
  logic [7:0] ir;
  logic       inta_neg;
  logic [7:0] imr;
  logic       level;
  logic       aeoi;
  logic       rot;
  logic [4:0] base;
  logic       ocw2;
  logic [2:0] cbits;
  logic [2:0] lvl;
  logic       ready;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_oe;
  logic [7:0] irr;
  logic [7:0] isr;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp;
  logic       prev_oe = 1'b0;
  logic [7:0] exp_rot;

  always #5 clk = ~clk;

  pic_priority_inta_sequencer dut (
    .clk                                   (clk),
    .rst_neg                               (rst_neg),
    .ir                                    (ir),
    .inta_neg                              (inta_neg),
    .imr                                   (imr),
    .level_trigger_flag_and_edge_level_neg (level),
    .aeoi_and_eoi_neg_flag                 (aeoi),
    .automatic_rotation_mode_flag          (rot),
    .last_five_bits_of_vector_address      (base),
    .ocw2_output_flag                      (ocw2),
    .control_bits                          (cbits),
    .ir_level                              (lvl),
    .ready_to_accept_interrupts_flag       (ready),
    .int_out                               (int_out),
    .vector_out                            (vector_out),
    .vector_oe                             (vector_oe),
    .irr                                   (irr),
    .isr                                   (isr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic inta_pulse();
    inta_neg = 1'b0;
    cyc(6);
    inta_neg = 1'b1;
    cyc(6);
  endtask

  task automatic ack(input logic [7:0] exp_vec);
    sb_q.push_back(exp_vec);
    inta_pulse();
    inta_pulse();
  endtask

  task automatic ocw2_wr(input logic [2:0] code, input logic [2:0] l);
    cbits = code;
    lvl   = l;
    ocw2  = ~ocw2;
    cyc(6);
  endtask

  // Pop the expected vector whenever the DUT starts driving one
  always @(negedge clk) begin
    if (vector_oe && !prev_oe) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_vector", 32'(vector_out), 32'hFFFF_FFFF);
      end else begin
        sb_exp = sb_q.pop_front();
        check_eq("vector", 32'(vector_out), 32'(sb_exp));
      end
    end
    prev_oe = vector_oe;
  end

  initial begin
    rst_neg = 1'b0; ir = 8'h00; inta_neg = 1'b1; imr = 8'h00; level = 1'b0;
    aeoi = 1'b0; rot = 1'b0; base = 5'b01000; ocw2 = 1'b0; cbits = 3'b000;
    lvl = 3'd0; ready = 1'b0;
    cyc(3);
    check_eq("rst_int", 32'(int_out), 32'd0);
    check_eq("rst_oe", 32'(vector_oe), 32'd0);
    check_eq("rst_vec", 32'(vector_out), 32'h00);
    check_eq("rst_irr", 32'(irr), 32'h00);
    check_eq("rst_isr", 32'(isr), 32'h00);
    rst_neg = 1'b1;
    ready   = 1'b1;
    cyc(4);

    // Basic acknowledge of IR3
    ir = 8'h08; cyc(5);
    check_eq("basic_int", 32'(int_out), 32'd1);
    check_eq("basic_irr", 32'(irr), 32'h08);
    ack(8'h43);
    check_eq("basic_isr", 32'(isr), 32'h08);
    check_eq("basic_irr_clr", 32'(irr), 32'h00);
    check_eq("basic_int_low", 32'(int_out), 32'd0);
    ocw2_wr(3'b000, 3'd3);
    check_eq("ocw2_nop_isr", 32'(isr), 32'h08);

    // Nesting: lower priority blocked, higher priority interrupts
    ir = 8'h28; cyc(5);
    check_eq("nest_irr5", 32'(irr), 32'h20);
    check_eq("nest_int_blocked", 32'(int_out), 32'd0);
    ir = 8'h2A; cyc(5);
    check_eq("nest_int_hi", 32'(int_out), 32'd1);
    ocw2_wr(3'b001, 3'd0);
    check_eq("nest_ns_eoi", 32'(isr), 32'h00);
    ack(8'h41);
    check_eq("nest_isr1", 32'(isr), 32'h02);
    check_eq("nest_int_after", 32'(int_out), 32'd0);
    ocw2_wr(3'b001, 3'd0);
    ack(8'h45);
    check_eq("nest_isr5", 32'(isr), 32'h20);
    ocw2_wr(3'b011, 3'd5);
    check_eq("spec_eoi", 32'(isr), 32'h00);
    ir = 8'h00; cyc(5);
    check_eq("idle_irr", 32'(irr), 32'h00);
    check_eq("idle_int", 32'(int_out), 32'd0);

    // Rotation via OCW2 set-priority and rotate-on-specific-EOI
    ocw2_wr(3'b110, 3'd2);
    ir = 8'h0C; cyc(5);
    check_eq("rot_int", 32'(int_out), 32'd1);
    ack(8'h43);
    check_eq("rot_isr", 32'(isr), 32'h08);
    check_eq("rot_irr", 32'(irr), 32'h04);
    ocw2_wr(3'b111, 3'd3);
    check_eq("rot_sp_eoi", 32'(isr), 32'h00);
    ir = 8'h00; cyc(5);
    ir = 8'h0C; cyc(5);
    ack(8'h42);
    check_eq("rot_isr2", 32'(isr), 32'h04);
    ocw2_wr(3'b011, 3'd2);
    ocw2_wr(3'b110, 3'd7);
    ir = 8'h00; cyc(5);

    // Auto-EOI, with optional rotation
    aeoi = 1'b1; rot = 1'b1;
    ir = 8'h01; cyc(5);
    sb_q.push_back(8'h40);
    inta_pulse();
    check_eq("aeoi_mid_isr", 32'(isr), 32'h01);
    inta_pulse();
    check_eq("aeoi_end_isr", 32'(isr), 32'h00);
    ir = 8'h00; cyc(5);
`ifdef AEOI_ROTATE_EN
    exp_rot = 8'h41;
`else
    exp_rot = 8'h40;
`endif
    ir = 8'h03; cyc(5);
    ack(exp_rot);
    check_eq("aeoi_isr2", 32'(isr), 32'h00);
    ir = 8'h00; aeoi = 1'b0; rot = 1'b0;
    ocw2_wr(3'b110, 3'd7);

    // Spurious acknowledge after the request disappears
    ir = 8'h40; cyc(5);
    ack(8'h46);
    ir = 8'h50; cyc(5);
    check_eq("spur_int", 32'(int_out), 32'd1);
    ir = 8'h40; cyc(5);
    check_eq("spur_irr", 32'(irr), 32'h00);
    check_eq("spur_int_drop", 32'(int_out), 32'd0);
    ack(8'h47);
    check_eq("spur_isr", 32'(isr), 32'h40);
    ocw2_wr(3'b001, 3'd0);
    check_eq("spur_eoi", 32'(isr), 32'h00);
    ir = 8'h00; cyc(5);

    // Level mode with mask, then reset in the middle of the sequence
    level = 1'b1; imr = 8'h10; ir = 8'h10; cyc(5);
    check_eq("lvl_irr", 32'(irr), 32'h10);
    check_eq("lvl_masked_int", 32'(int_out), 32'd0);
    imr = 8'h00; cyc(3);
    check_eq("lvl_unmask_int", 32'(int_out), 32'd1);
    inta_pulse();
    check_eq("wait2_isr", 32'(isr), 32'h10);
    check_eq("wait2_int", 32'(int_out), 32'd0);
    check_eq("wait2_irr_level", 32'(irr), 32'h10);
    #1 rst_neg = 1'b0;
    #1;
    check_eq("mid_rst_int", 32'(int_out), 32'd0);
    check_eq("mid_rst_oe", 32'(vector_oe), 32'd0);
    check_eq("mid_rst_vec", 32'(vector_out), 32'h00);
    check_eq("mid_rst_irr", 32'(irr), 32'h00);
    check_eq("mid_rst_isr", 32'(isr), 32'h00);
    cyc(1);
    rst_neg = 1'b1;
    cyc(6);
    check_eq("post_rst_int", 32'(int_out), 32'd1);
    check_eq("post_rst_isr", 32'(isr), 32'h00);

    check_eq("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
